// File: rtl/phy_pkg.sv
// Shared constants and FSM encoding for the serial byte receiver.
// The comma byte marks byte alignment; LOCK_COMMAS aligned commas are needed to lock.
package phy_pkg;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int unsigned LOCK_COMMAS = 4;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StSync   = 2'd1,
    StActive = 2'd2
  } rx_state_e;

  function automatic logic is_comma(input logic [7:0] b);
    return b == COMMA;
  endfunction

endpackage

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: hunts for the comma byte, locks after four aligned commas,
// then delivers one registered data byte per eight bit clocks.
module serial_to_parallel_rx
  import phy_pkg::*;
(
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_tick
);

  localparam logic [2:0] LockLast = 3'(LOCK_COMMAS - 1);

  rx_state_e  state_q, state_d;
  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
  logic       tick_q, tick_d;

  logic [7:0] cand;
  logic       boundary;
  logic       cand_comma;

  // Only the low seven bits of the shift register ever reach the next candidate.
  assign cand       = {shift_q, data_in};
  assign boundary   = (bit_cnt_q == 3'd7);
  assign cand_comma = is_comma(cand);
  assign shift_d    = cand[6:0];

  // State register
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q <= StSearch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    unique case (state_q)
      StSearch: begin
        bit_cnt_d = 3'd0;
        if (cand_comma) begin
          state_d  = StSync;
          bc_cnt_d = 3'd1;
        end
      end
      StSync: begin
        if (boundary) begin
          if (!cand_comma) begin
            state_d  = StSearch;
            bc_cnt_d = 3'd0;
          end else if (bc_cnt_q == LockLast) begin
            state_d  = StActive;
            bc_cnt_d = 3'd0;
          end else begin
            bc_cnt_d = bc_cnt_q + 3'd1;
          end
        end
      end
      StActive: begin
        state_d = StActive;
      end
      default: begin
        state_d  = StSearch;
        bc_cnt_d = 3'd0;
      end
    endcase
  end

  // Output logic; every output is a flop so nothing combinational leaves the block
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = valid_q;
    tick_d     = 1'b0;
    active_d   = (state_d == StActive);
    if ((state_q == StActive) && boundary) begin
      tick_d = 1'b1;
      if (cand_comma) begin
        valid_d = 1'b0;
      end else begin
        data_out_d = cand;
        valid_d    = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      shift_q    <= 7'd0;
      bit_cnt_q  <= 3'd0;
      bc_cnt_q   <= 3'd0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      bc_cnt_q   <= bc_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      tick_q     <= tick_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign active    = active_q;
  assign byte_tick = tick_q;

endmodule
